// File: rtl/tm_spike_aer.sv
// Spike-vector to address-event serialiser: one vector is captured per timestep, then
// its set bits are emitted lowest-first as {ts, addr} words through a fall-through FIFO.
module tm_spike_aer #(
   parameter int N_NEURONS  = 8,
   parameter int ADDR_W     = 3,
   parameter int TS_W       = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_NEURONS-1:0] spike_in,
   input  logic                 spike_valid,
   input  logic                 ovf_clr,
   output logic                 aer_valid,
   input  logic                 aer_ready,
   output logic [ADDR_W-1:0]    aer_addr,
   output logic [TS_W-1:0]      aer_ts,
   output logic                 busy,
   output logic                 overflow
);

   localparam int FIFO_AW = $clog2(FIFO_DEPTH);
   localparam int EVT_W   = TS_W + ADDR_W;
   localparam logic [FIFO_AW:0] PTR_ONE = 1;
   localparam logic [TS_W-1:0]  TS_ONE  = 1;

   logic [TS_W-1:0]      ts_cnt_q, ts_cnt_d;
   logic [TS_W-1:0]      cap_ts_q, cap_ts_d;
   logic [N_NEURONS-1:0] pending_q, pending_d;
   logic                 overflow_q, overflow_d;
   logic [FIFO_AW:0]     wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW:0]     rd_ptr_q, rd_ptr_d;
   logic [EVT_W-1:0]     mem_q [FIFO_DEPTH];

   logic                 pendingNz;
   logic                 fifoEmpty;
   logic                 fifoFull;
   logic                 doPush;
   logic                 doPop;
   logic [ADDR_W-1:0]    scanIdx;
   logic [EVT_W-1:0]     headWord;

   assign pendingNz = |pending_q;
   assign fifoEmpty = (wr_ptr_q == rd_ptr_q);
   assign fifoFull  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign doPush    = pendingNz && !fifoFull;
   assign doPop     = !fifoEmpty && aer_ready;

   // Descending walk so the lowest set bit is the last (winning) assignment.
   always_comb begin
      scanIdx = '0;
      for (int k = N_NEURONS - 1; k >= 0; k--) begin
         if (pending_q[k]) begin
            scanIdx = ADDR_W'(k);
         end
      end
   end

   always_comb begin
      ts_cnt_d   = ts_cnt_q;
      cap_ts_d   = cap_ts_q;
      pending_d  = pending_q;
      overflow_d = overflow_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      if (doPush) begin
         pending_d[scanIdx] = 1'b0;
         wr_ptr_d           = wr_ptr_q + PTR_ONE;
      end
      if (doPop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      // A new vector is only taken once the previous one is fully serialised.
      if (spike_valid) begin
         ts_cnt_d = ts_cnt_q + TS_ONE;
         if (!pendingNz) begin
            pending_d = spike_in;
            cap_ts_d  = ts_cnt_q;
         end
      end

      if (spike_valid && pendingNz) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ts_cnt_q   <= '0;
         cap_ts_q   <= '0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         ts_cnt_q   <= ts_cnt_d;
         cap_ts_q   <= cap_ts_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst_n && doPush) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {cap_ts_q, scanIdx};
      end
   end

   assign headWord  = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign aer_valid = !fifoEmpty;
   assign aer_addr  = fifoEmpty ? '0 : headWord[ADDR_W-1:0];
   assign aer_ts    = fifoEmpty ? '0 : headWord[EVT_W-1:ADDR_W];
   assign busy      = pendingNz || !fifoEmpty;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_tm_spike_aer.sv
// Directed bench for tm_spike_aer: a default-depth instance plus a depth-4 instance
// for the scan-stall case, both sharing clock and reset.
module tb_tm_spike_aer;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] spikeIn;
   logic       spikeValid;
   logic       ovfClr;
   logic       aerReady;
   logic       aerValid;
   logic [2:0] aerAddr;
   logic [7:0] aerTs;
   logic       busyO;
   logic       overflowO;

   logic [7:0] spikeIn4;
   logic       spikeValid4;
   logic       ovfClr4;
   logic       aerReady4;
   logic       aerValid4;
   logic [2:0] aerAddr4;
   logic [7:0] aerTs4;
   logic       busyO4;
   logic       overflowO4;

   int nCompared   = 0;
   int nMismatched = 0;

   always #5 clk = ~clk;

   tm_spike_aer #(.N_NEURONS(8), .ADDR_W(3), .TS_W(8), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spike_in   (spikeIn),
      .spike_valid(spikeValid),
      .ovf_clr    (ovfClr),
      .aer_valid  (aerValid),
      .aer_ready  (aerReady),
      .aer_addr   (aerAddr),
      .aer_ts     (aerTs),
      .busy       (busyO),
      .overflow   (overflowO)
   );

   tm_spike_aer #(.N_NEURONS(8), .ADDR_W(3), .TS_W(8), .FIFO_DEPTH(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .spike_in   (spikeIn4),
      .spike_valid(spikeValid4),
      .ovf_clr    (ovfClr4),
      .aer_valid  (aerValid4),
      .aer_ready  (aerReady4),
      .aer_addr   (aerAddr4),
      .aer_ts     (aerTs4),
      .busy       (busyO4),
      .overflow   (overflowO4)
   );

   // Advance to 1 time unit after the next rising edge; inputs and checks happen there.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      spikeIn = '0;  spikeValid = 1'b0;  ovfClr = 1'b0;  aerReady = 1'b0;
      spikeIn4 = '0; spikeValid4 = 1'b0; ovfClr4 = 1'b0; aerReady4 = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input logic [7:0] vec);
      spikeIn    = vec;
      spikeValid = 1'b1;
      step();
      spikeValid = 1'b0;
   endtask

   initial begin
      $display("[TB] start");
      applyReset();
      checkOutput("rst_valid", aerValid, 0);
      checkOutput("rst_busy", busyO, 0);
      checkOutput("rst_ovf", overflowO, 0);
      checkOutput("rst_addr", aerAddr, 0);
      checkOutput("rst_ts", aerTs, 0);

      // Sparse vector streamed straight through with the consumer always ready.
      aerReady = 1'b1;
      applyStimulus(8'b1010_0101);
      checkOutput("t1_lat_valid", aerValid, 0);
      checkOutput("t1_lat_busy", busyO, 1);
      step();
      checkOutput("t1_ev0_valid", aerValid, 1);
      checkOutput("t1_ev0_addr", aerAddr, 0);
      checkOutput("t1_ev0_ts", aerTs, 0);
      step();
      checkOutput("t1_ev1_addr", aerAddr, 2);
      step();
      checkOutput("t1_ev2_addr", aerAddr, 5);
      step();
      checkOutput("t1_ev3_addr", aerAddr, 7);
      checkOutput("t1_ev3_busy", busyO, 1);
      step();
      checkOutput("t1_end_valid", aerValid, 0);
      checkOutput("t1_end_busy", busyO, 0);
      checkOutput("t1_end_ovf", overflowO, 0);

      // Back-to-back strobes: the second vector is dropped but still advances ts.
      applyReset();
      aerReady   = 1'b1;
      spikeIn    = 8'hFF;
      spikeValid = 1'b1;
      step();
      spikeIn    = 8'h0F;
      step();
      spikeValid = 1'b0;
      checkOutput("t2_ovf_set", overflowO, 1);
      checkOutput("t2_ev0_addr", aerAddr, 0);
      checkOutput("t2_ev0_ts", aerTs, 0);
      for (int i = 1; i < 8; i++) begin
         step();
         checkOutput($sformatf("t2_ev%0d_addr", i), aerAddr, i);
         checkOutput($sformatf("t2_ev%0d_ts", i), aerTs, 0);
      end
      step();
      checkOutput("t2_no_extra", aerValid, 0);
      ovfClr = 1'b1;
      step();
      ovfClr = 1'b0;
      checkOutput("t2_ovf_clr", overflowO, 0);
      applyStimulus(8'h01);
      step();
      checkOutput("t2_ts_after_drop", aerTs, 2);
      checkOutput("t2_addr_after_drop", aerAddr, 0);
      step();
      checkOutput("t2_end_valid", aerValid, 0);

      // Consumer stalled: the FIFO fills completely, then drains in address order.
      applyReset();
      applyStimulus(8'hFF);
      for (int i = 0; i < 10; i++) step();
      checkOutput("t3_full_valid", aerValid, 1);
      checkOutput("t3_full_head", aerAddr, 0);
      checkOutput("t3_full_busy", busyO, 1);
      aerReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("t3_drain%0d_valid", i), aerValid, 1);
         checkOutput($sformatf("t3_drain%0d_addr", i), aerAddr, i);
         step();
      end
      checkOutput("t3_end_valid", aerValid, 0);
      checkOutput("t3_end_busy", busyO, 0);

      // Depth-4 FIFO: the scan stalls with bits 4..7 still pending.
      applyReset();
      spikeIn4    = 8'hFF;
      spikeValid4 = 1'b1;
      step();
      spikeValid4 = 1'b0;
      for (int i = 0; i < 6; i++) step();
      checkOutput("t4_stall_head", aerAddr4, 0);
      checkOutput("t4_stall_busy", busyO4, 1);
      spikeIn4    = 8'h01;
      spikeValid4 = 1'b1;
      ovfClr4     = 1'b1;
      step();
      spikeValid4 = 1'b0;
      ovfClr4     = 1'b0;
      checkOutput("t4_ovf_priority", overflowO4, 1);
      aerReady4 = 1'b1;
      step();
      aerReady4 = 1'b0;
      checkOutput("t4_pulse_head", aerAddr4, 1);
      step();
      aerReady4 = 1'b1;
      for (int i = 1; i < 8; i++) begin
         checkOutput($sformatf("t4_drain%0d_addr", i), aerAddr4, i);
         checkOutput($sformatf("t4_drain%0d_ts", i), aerTs4, 0);
         step();
      end
      checkOutput("t4_end_valid", aerValid4, 0);
      checkOutput("t4_end_busy", busyO4, 0);
      aerReady4 = 1'b0;

      // 256 empty timesteps wrap the timestep counter back to zero.
      applyReset();
      aerReady   = 1'b1;
      spikeIn    = 8'h00;
      spikeValid = 1'b1;
      for (int i = 0; i < 256; i++) step();
      spikeValid = 1'b0;
      checkOutput("t5_zero_valid", aerValid, 0);
      checkOutput("t5_zero_busy", busyO, 0);
      applyStimulus(8'h01);
      step();
      checkOutput("t5_wrap_valid", aerValid, 1);
      checkOutput("t5_wrap_addr", aerAddr, 0);
      checkOutput("t5_wrap_ts", aerTs, 0);
      step();
      checkOutput("t5_end_valid", aerValid, 0);

      // Reset while events are queued and overflow is set.
      applyReset();
      spikeIn    = 8'h07;
      spikeValid = 1'b1;
      step();
      spikeIn    = 8'h01;
      step();
      spikeValid = 1'b0;
      step();
      step();
      checkOutput("t6_queued_valid", aerValid, 1);
      checkOutput("t6_queued_ovf", overflowO, 1);
      rst_n = 1'b0;
      step();
      checkOutput("t6_rst_valid", aerValid, 0);
      checkOutput("t6_rst_busy", busyO, 0);
      checkOutput("t6_rst_ovf", overflowO, 0);
      checkOutput("t6_rst_addr", aerAddr, 0);
      rst_n    = 1'b1;
      aerReady = 1'b1;
      applyStimulus(8'h08);
      step();
      checkOutput("t6_post_addr", aerAddr, 3);
      checkOutput("t6_post_ts", aerTs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
